// File: rtl/btb_predict_queue.sv
// Fetch-side BTB lookup with an in-order queue of outstanding predictions and mispredict redirect.
// Optional statistics counters are enabled by defining BTB_PQ_STATS_EN.
module btb_predict_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int CW    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_valid,
    input  logic [AW-1:0]   fetch_pc,
    output logic            fetch_ready,
    input  logic [7:0]      tbl_v,
    input  logic [8*AW-1:0] tbl_a,
    input  logic [8*AW-1:0] tbl_b,
    input  logic [15:0]     tbl_s,
    output logic            pred_valid,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [AW-1:0]   pred_npc,
    input  logic            res_valid,
    input  logic [AW-1:0]   res_pc,
    input  logic            res_taken,
    input  logic [AW-1:0]   res_target,
    output logic            redirect,
    output logic [AW-1:0]   redirect_pc,
    output logic            sync_err,
    output logic [CW-1:0]   n_resolved,
    output logic [CW-1:0]   n_mispred
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [AW-1:0] pc_q  [DEPTH];
    logic [AW-1:0] npc_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]   count_q, count_d;

    logic          pred_valid_q, pred_hit_q, pred_taken_q;
    logic [AW-1:0] pred_npc_q;
    logic          redirect_q;
    logic [AW-1:0] redirect_pc_q;
    logic          sync_err_q, sync_err_d;

    logic          lk_hit, lk_taken;
    logic [AW-1:0] lk_target, lk_npc;

    logic          q_full, q_empty, pop, accept, pc_mismatch, redirect_next;
    logic [AW-1:0] head_pc, head_npc, res_actual;

    // Descending scan so the lowest matching entry is the one left standing.
    always_comb begin
        lk_hit    = 1'b0;
        lk_taken  = 1'b0;
        lk_target = '0;
        for (int i = 7; i >= 0; i--) begin
            if (tbl_v[i] && (tbl_a[i*AW +: AW] == fetch_pc)) begin
                lk_hit    = 1'b1;
                lk_taken  = tbl_s[2*i+1];
                lk_target = tbl_b[i*AW +: AW];
            end
        end
        lk_npc = lk_taken ? lk_target : fetch_pc + AW'(4);
    end

    always_comb begin
        q_full        = (count_q == FULL_CNT);
        q_empty       = (count_q == '0);
        head_pc       = pc_q[rd_q];
        head_npc      = npc_q[rd_q];
        res_actual    = res_taken ? res_target : res_pc + AW'(4);
        pop           = res_valid && !q_empty;
        pc_mismatch   = (head_pc != res_pc);
        redirect_next = pop && ((head_npc != res_actual) || pc_mismatch);
        fetch_ready   = !q_full || res_valid;
        accept        = fetch_valid && fetch_ready && !redirect_next;
        sync_err_d    = sync_err_q || (res_valid && (q_empty || pc_mismatch));
    end

    // A mispredict flushes everything, including a push offered in the same cycle.
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (redirect_next) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            if (accept) begin
                wr_d = wr_q + 1'b1;
            end
            count_d = count_q + {{PW{1'b0}}, accept} - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]  <= '0;
                npc_q[i] <= '0;
            end
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            if (accept) begin
                pc_q[wr_q]  <= fetch_pc;
                npc_q[wr_q] <= lk_npc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_npc_q    <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            sync_err_q    <= 1'b0;
        end else begin
            pred_valid_q <= accept;
            if (accept) begin
                pred_hit_q   <= lk_hit;
                pred_taken_q <= lk_taken;
                pred_npc_q   <= lk_npc;
            end
            redirect_q <= redirect_next;
            if (redirect_next) begin
                redirect_pc_q <= res_actual;
            end
            sync_err_q <= sync_err_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_hit    = pred_hit_q;
    assign pred_taken  = pred_taken_q;
    assign pred_npc    = pred_npc_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign sync_err    = sync_err_q;

`ifdef BTB_PQ_STATS_EN
    logic [CW-1:0] n_resolved_q, n_mispred_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_resolved_q <= '0;
            n_mispred_q  <= '0;
        end else begin
            if (pop && (n_resolved_q != '1)) begin
                n_resolved_q <= n_resolved_q + 1'b1;
            end
            if (redirect_next && (n_mispred_q != '1)) begin
                n_mispred_q <= n_mispred_q + 1'b1;
            end
        end
    end

    assign n_resolved = n_resolved_q;
    assign n_mispred  = n_mispred_q;
`else
    assign n_resolved = '0;
    assign n_mispred  = '0;
`endif

endmodule

// File: tb/tb_btb_predict_queue.sv
// Self-checking bench for btb_predict_queue: vector table, hand sequences and a randomized
// run against a queue-based reference model.
module tb_btb_predict_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int CW    = 2;
`ifdef BTB_PQ_STATS_EN
    localparam int SAT = (1 << CW) - 1;
`else
    localparam int SAT = 0;
`endif

    logic            clk;
    logic            rst_n;
    logic            fetch_valid;
    logic [AW-1:0]   fetch_pc;
    logic            fetch_ready;
    logic [7:0]      tbl_v;
    logic [8*AW-1:0] tbl_a;
    logic [8*AW-1:0] tbl_b;
    logic [15:0]     tbl_s;
    logic            pred_valid, pred_hit, pred_taken;
    logic [AW-1:0]   pred_npc;
    logic            res_valid;
    logic [AW-1:0]   res_pc;
    logic            res_taken;
    logic [AW-1:0]   res_target;
    logic            redirect;
    logic [AW-1:0]   redirect_pc;
    logic            sync_err;
    logic [CW-1:0]   n_resolved, n_mispred;

    btb_predict_queue #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
        .tbl_v(tbl_v), .tbl_a(tbl_a), .tbl_b(tbl_b), .tbl_s(tbl_s),
        .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_npc(pred_npc),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
        .redirect(redirect), .redirect_pc(redirect_pc), .sync_err(sync_err),
        .n_resolved(n_resolved), .n_mispred(n_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
    } qent_t;

    typedef struct {
        logic [31:0] pc;
        bit          hit;
        bit          taken;
        logic [31:0] npc;
    } vec_t;

    qent_t       mq[$];
    vec_t        vecs[8];
    logic [31:0] ta[8];
    logic [31:0] tt[8];
    logic [1:0]  ts[8];
    logic [7:0]  tv;

    int checks = 0;
    int errors = 0;
    int exp_nres = 0;
    int exp_nmis = 0;
    bit exp_sync = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic loadTable();
        tbl_v = tv;
        for (int i = 0; i < 8; i++) begin
            tbl_a[i*AW +: AW] = ta[i];
            tbl_b[i*AW +: AW] = tt[i];
            tbl_s[2*i +: 2]   = ts[i];
        end
    endtask

    task automatic setIdle();
        fetch_valid = 1'b0;
        fetch_pc    = '0;
        res_valid   = 1'b0;
        res_pc      = '0;
        res_taken   = 1'b0;
        res_target  = '0;
    endtask

    function automatic void modelLookup(input logic [31:0] pc, output bit hit, output bit tk,
                                        output logic [31:0] npc);
        hit = 0;
        tk  = 0;
        npc = pc + 32'd4;
        for (int i = 0; i < 8; i++) begin
            if (!hit && tv[i] && ta[i] == pc) begin
                hit = 1;
                tk  = (ts[i] >= 2'd2);
                if (tk) npc = tt[i];
            end
        end
    endfunction

    function automatic int satInc(input int v);
        return (v + 1 > SAT) ? SAT : v + 1;
    endfunction

    // One clock of stimulus: inputs are already driven; predict, clock, compare.
    task automatic applyStimulus();
        bit          ready, acc, pop, mis, hit, tk;
        logic [31:0] npc, actual, fpc;
        #1;
        ready = (mq.size() < DEPTH) || res_valid;
        checkOutput("fetch_ready", {31'd0, fetch_ready}, {31'd0, ready});
        fpc = fetch_pc;
        modelLookup(fpc, hit, tk, npc);
        pop    = res_valid && (mq.size() > 0);
        actual = res_taken ? res_target : res_pc + 32'd4;
        mis    = 0;
        if (res_valid) begin
            if (mq.size() == 0) begin
                exp_sync = 1;
            end else begin
                if (mq[0].pc != res_pc) begin
                    exp_sync = 1;
                    mis = 1;
                end
                if (mq[0].npc != actual) mis = 1;
            end
        end
        acc = fetch_valid && ready && !mis;
        @(posedge clk);
        #1;
        if (mis) begin
            mq.delete();
        end else begin
            if (pop) mq.delete(0);
            if (acc) mq.push_back('{fpc, npc});
        end
        if (pop) exp_nres = satInc(exp_nres);
        if (mis) exp_nmis = satInc(exp_nmis);
        checkOutput("pred_valid", {31'd0, pred_valid}, {31'd0, acc});
        if (acc) begin
            checkOutput("pred_hit", {31'd0, pred_hit}, {31'd0, hit});
            checkOutput("pred_taken", {31'd0, pred_taken}, {31'd0, tk});
            checkOutput("pred_npc", pred_npc, npc);
        end
        checkOutput("redirect", {31'd0, redirect}, {31'd0, mis});
        if (mis) checkOutput("redirect_pc", redirect_pc, actual);
        checkOutput("sync_err", {31'd0, sync_err}, {31'd0, exp_sync});
        checkOutput("n_resolved", {30'd0, n_resolved}, 32'(exp_nres));
        checkOutput("n_mispred", {30'd0, n_mispred}, 32'(exp_nmis));
    endtask

    task automatic checkResetState();
        checkOutput("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
        checkOutput("rst_pred_hit", {31'd0, pred_hit}, 32'd0);
        checkOutput("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        checkOutput("rst_pred_npc", pred_npc, 32'd0);
        checkOutput("rst_redirect", {31'd0, redirect}, 32'd0);
        checkOutput("rst_redirect_pc", redirect_pc, 32'd0);
        checkOutput("rst_sync_err", {31'd0, sync_err}, 32'd0);
        checkOutput("rst_n_resolved", {30'd0, n_resolved}, 32'd0);
        checkOutput("rst_n_mispred", {30'd0, n_mispred}, 32'd0);
        checkOutput("rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
    endtask

    // Asynchronous reset between clock edges, then release on a falling edge.
    task automatic resetMidStream();
        setIdle();
        rst_n = 1'b0;
        #1;
        checkResetState();
        mq.delete();
        exp_sync = 0;
        exp_nres = 0;
        exp_nmis = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic fetchOne(input logic [31:0] pc);
        setIdle();
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        applyStimulus();
    endtask

    task automatic resolveOne(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        setIdle();
        res_valid  = 1'b1;
        res_pc     = pc;
        res_taken  = tk;
        res_target = tgt;
        applyStimulus();
    endtask

    initial begin
        tv = 8'b1111_1101;
        ta[0] = 32'h1000;     tt[0] = 32'h2000; ts[0] = 2'd3;
        ta[1] = 32'h1100;     tt[1] = 32'h2100; ts[1] = 2'd3;
        ta[2] = 32'h1200;     tt[2] = 32'h2200; ts[2] = 2'd1;
        ta[3] = 32'h40;       tt[3] = 32'h80;   ts[3] = 2'd2;
        ta[4] = 32'h1400;     tt[4] = 32'h2400; ts[4] = 2'd0;
        ta[5] = 32'h1200;     tt[5] = 32'h2500; ts[5] = 2'd3;
        ta[6] = 32'hFFFFFFFC; tt[6] = 32'h10;   ts[6] = 2'd0;
        ta[7] = 32'h1700;     tt[7] = 32'h2700; ts[7] = 2'd3;

        vecs[0] = '{32'h1000,     1, 1, 32'h2000};
        vecs[1] = '{32'h1100,     0, 0, 32'h1104};
        vecs[2] = '{32'h1200,     1, 0, 32'h1204};
        vecs[3] = '{32'h40,       1, 1, 32'h80};
        vecs[4] = '{32'h1400,     1, 0, 32'h1404};
        vecs[5] = '{32'hFFFFFFFC, 1, 0, 32'h0};
        vecs[6] = '{32'h1700,     1, 1, 32'h2700};
        vecs[7] = '{32'h5550,     0, 0, 32'h5554};

        loadTable();
        setIdle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven lookups, each resolved consistently so no redirect follows.
        for (int k = 0; k < 8; k++) begin
            fetchOne(vecs[k].pc);
            checkOutput("vec_hit", {31'd0, pred_hit}, {31'd0, vecs[k].hit});
            checkOutput("vec_taken", {31'd0, pred_taken}, {31'd0, vecs[k].taken});
            checkOutput("vec_npc", pred_npc, vecs[k].npc);
            resolveOne(vecs[k].pc, vecs[k].taken, vecs[k].npc);
            checkOutput("vec_no_redirect", {31'd0, redirect}, 32'd0);
        end

        // Weakly not-taken entry, branch actually taken: redirect and drop the same-cycle fetch.
        ts[3] = 2'd1;
        loadTable();
        fetchOne(32'h40);
        checkOutput("wnt_npc", pred_npc, 32'h44);
        setIdle();
        res_valid = 1'b1; res_pc = 32'h40; res_taken = 1'b1; res_target = 32'h80;
        fetch_valid = 1'b1; fetch_pc = 32'h1000;
        applyStimulus();
        checkOutput("mp_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("mp_redirect_pc", redirect_pc, 32'h80);
        checkOutput("mp_fetch_dropped", {31'd0, pred_valid}, 32'd0);
        setIdle();
        applyStimulus();
        checkOutput("mp_pulse_end", {31'd0, redirect}, 32'd0);

        // Reset while a redirect pulse is live.
        fetchOne(32'h40);
        resolveOne(32'h40, 1'b1, 32'h80);
        resetMidStream();
        ts[3] = 2'd2;
        loadTable();

        // Fill to DEPTH, stall, then push and pop in the same cycle while full.
        for (int k = 0; k < DEPTH; k++) fetchOne(32'(4 * k));
        fetchOne(32'h10);
        checkOutput("full_not_ready", {31'd0, fetch_ready}, 32'd0);
        setIdle();
        fetch_valid = 1'b1; fetch_pc = 32'h10;
        res_valid = 1'b1; res_pc = 32'h0; res_taken = 1'b0;
        applyStimulus();
        checkOutput("pushpop_no_redirect", {31'd0, redirect}, 32'd0);
        checkOutput("pushpop_pred_valid", {31'd0, pred_valid}, 32'd1);
        setIdle();
        #1;
        checkOutput("pushpop_still_full", {31'd0, fetch_ready}, 32'd0);
        for (int k = 1; k <= DEPTH; k++) resolveOne(32'(4 * k), 1'b0, 32'h0);

        // Resolution on an empty queue, then a PC mismatch against the head.
        resolveOne(32'h200, 1'b0, 32'h0);
        checkOutput("empty_res_sync", {31'd0, sync_err}, 32'd1);
        resetMidStream();
        fetchOne(32'h0);
        resolveOne(32'h100, 1'b0, 32'h0);
        checkOutput("pcmis_sync", {31'd0, sync_err}, 32'd1);
        checkOutput("pcmis_redirect", {31'd0, redirect}, 32'd1);
        setIdle();
        applyStimulus();
        checkOutput("sync_sticky", {31'd0, sync_err}, 32'd1);

        // Five mispredicts: counter saturates when stats are built in, otherwise stays 0.
        resetMidStream();
        for (int k = 0; k < 5; k++) begin
            fetchOne(32'h40);
            resolveOne(32'h40, 1'b0, 32'h0);
        end
        checkOutput("n_mispred_sat", {30'd0, n_mispred}, 32'((5 > SAT) ? SAT : 5));

        // Randomized traffic against the reference model.
        resetMidStream();
        for (int it = 0; it < 800; it++) begin
            if ($urandom_range(0, 99) < 2) begin
                resetMidStream();
            end
            if ($urandom_range(0, 99) < 4) begin
                ts[$urandom_range(0, 7)] = 2'($urandom_range(0, 3));
                tv[$urandom_range(0, 7)] = 1'($urandom_range(0, 1));
                loadTable();
            end
            setIdle();
            fetch_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 0) fetch_pc = ta[$urandom_range(0, 7)];
            else fetch_pc = $urandom() & 32'hFFFF_FFFC;
            if (mq.size() > 0) begin
                res_valid = ($urandom_range(0, 99) < ((mq.size() == DEPTH) ? 60 : 35));
                res_pc    = ($urandom_range(0, 99) < 95) ? mq[0].pc : 32'($urandom());
                case ($urandom_range(0, 3))
                    0, 1: begin res_taken = 1'b1; res_target = mq[0].npc; end
                    2:    begin res_taken = 1'b0; res_target = 32'($urandom()); end
                    default: begin
                        res_taken  = 1'($urandom_range(0, 1));
                        res_target = (res_taken && $urandom_range(0, 1) == 1) ? mq[0].pc + 32'd4
                                                                              : 32'($urandom());
                    end
                endcase
            end else begin
                res_valid = ($urandom_range(0, 99) < 3);
                res_pc    = 32'($urandom());
            end
            applyStimulus();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
